pcs_link_monitor: RTL and testbench

Link monitor and PCS enable controller for the 100BASE-X PHY. It qualifies the synchronized PMD signal-detect with a stabilization timer and drives `link_status` into the PCS transmit and receive processes, which hold idle or flush while link is down. It also honours a management link-disable and keeps a saturating count of link failures for the management register block.

---
 rtl/pcs_link_monitor_pkg.sv | 14 +
 rtl/pcs_link_monitor.sv | 100 ++++++++++
 tb/tb_pcs_link_monitor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pcs_link_monitor_pkg.sv
// Shared definitions for the 100BASE-X link monitor; the management block
// imports this package to decode link_state.
package pcs_link_monitor_pkg;

  // Encoding 2'd3 is unused and recovers to LINK_DOWN.
  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    LINK_HOLD = 2'd1,
    LINK_UP   = 2'd2
  } link_state_e;

  localparam int unsigned LINK_STATE_WIDTH = 2;

endpackage

// File: rtl/pcs_link_monitor.sv
// Qualifies PMD signal-detect with a stabilization timer, drives the PCS
// link_status and keeps a saturating count of link failures.
module pcs_link_monitor
  import pcs_link_monitor_pkg::*;
#(
  parameter int unsigned STABILIZE_CYCLES = 41250,
  parameter int unsigned COUNT_WIDTH      = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        signal_status_i,
  input  logic                        disable_i,
  input  logic                        clear_count_i,
  output logic                        link_status_o,
  output logic [LINK_STATE_WIDTH-1:0] link_state_o,
  output logic [COUNT_WIDTH-1:0]      fail_count_o,
  output logic                        link_up_evt_o
);

  localparam int unsigned TIMER_WIDTH = $clog2(STABILIZE_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(STABILIZE_CYCLES - 1);

  link_state_e             state_q, state_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    link_status_q, link_status_d;
  logic                    link_up_evt_q, link_up_evt_d;
  logic                    ok;
  logic                    fail_inc;

  assign ok = signal_status_i && !disable_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= LINK_DOWN;
      timer_q       <= '0;
      count_q       <= '0;
      link_status_q <= 1'b0;
      link_up_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      link_status_q <= link_status_d;
      link_up_evt_q <= link_up_evt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    link_up_evt_d = 1'b0;
    fail_inc      = 1'b0;

    case (state_q)
      LINK_DOWN: begin
        timer_d = '0;
        if (ok) state_d = LINK_HOLD;
      end
      LINK_HOLD: begin
        if (!ok) begin
          state_d = LINK_DOWN;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d       = LINK_UP;
          link_up_evt_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
      LINK_UP: begin
        if (!ok) begin
          state_d  = LINK_DOWN;
          timer_d  = '0;
          fail_inc = 1'b1;
        end
      end
      default: begin
        state_d = LINK_DOWN;
        timer_d = '0;
      end
    endcase

    link_status_d = (state_d == LINK_UP);

    // A clear wins over the held value but still lets a same-cycle failure count as one.
    count_d = count_q;
    if (clear_count_i) begin
      count_d = fail_inc ? COUNT_WIDTH'(1) : '0;
    end else if (fail_inc && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  assign link_status_o = link_status_q;
  assign link_state_o  = state_q;
  assign fail_count_o  = count_q;
  assign link_up_evt_o = link_up_evt_q;

endmodule

// File: tb/tb_pcs_link_monitor.sv
// Directed self-checking bench for pcs_link_monitor (STABILIZE_CYCLES=4 and =1).
module tb_pcs_link_monitor;
  import pcs_link_monitor_pkg::*;

  logic       clock = 1'b0;
  logic       rstN;
  logic       sigStatus, disableLink, clearCount;
  logic       linkStatus, linkUpEvt;
  logic [1:0] linkState;
  logic [1:0] failCount;

  logic       sigMin;
  logic       linkStatusMin, linkUpEvtMin;
  logic [1:0] linkStateMin;
  logic [1:0] failCountMin;

  int assertCount = 0;
  int failCount_n = 0;

  always #5 clock = ~clock;

  pcs_link_monitor #(.STABILIZE_CYCLES(4), .COUNT_WIDTH(2)) dut (
    .clk_i          (clock),
    .rst_ni         (rstN),
    .signal_status_i(sigStatus),
    .disable_i      (disableLink),
    .clear_count_i  (clearCount),
    .link_status_o  (linkStatus),
    .link_state_o   (linkState),
    .fail_count_o   (failCount),
    .link_up_evt_o  (linkUpEvt)
  );

  pcs_link_monitor #(.STABILIZE_CYCLES(1), .COUNT_WIDTH(2)) dutMin (
    .clk_i          (clock),
    .rst_ni         (rstN),
    .signal_status_i(sigMin),
    .disable_i      (1'b0),
    .clear_count_i  (1'b0),
    .link_status_o  (linkStatusMin),
    .link_state_o   (linkStateMin),
    .fail_count_o   (failCountMin),
    .link_up_evt_o  (linkUpEvtMin)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed != expected) begin
      failCount_n++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, so they are stable at the next one.
  task automatic applyStimulus(input logic sig, input logic dis, input logic clr);
    sigStatus   = sig;
    disableLink = dis;
    clearCount  = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic bringUp(input string tag);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, "_status"}, linkStatus, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int expCount;
    logic [1:0] glitchStates [9];
    logic       glitchSig    [9];
    glitchSig    = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    glitchStates = '{1, 1, 1, 0, 1, 1, 1, 1, 2};

    rstN = 1'b0;
    sigMin = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst_status", linkStatus, 0);
    checkOutput("rst_state", linkState, 0);
    checkOutput("rst_count", failCount, 0);
    checkOutput("rst_evt", linkUpEvt, 0);
    checkOutput("rst_min_state", linkStateMin, 0);

    // Basic link-up: HOLD after edge 0, UP and event after edge 4.
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("up_state_%0d", i), linkState, (i < 4) ? 1 : 2);
      checkOutput($sformatf("up_status_%0d", i), linkStatus, (i == 4) ? 1 : 0);
      checkOutput($sformatf("up_evt_%0d", i), linkUpEvt, (i == 4) ? 1 : 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("up_evt_oneshot", linkUpEvt, 0);
    checkOutput("up_status_hold", linkStatus, 1);
    checkOutput("up_count", failCount, 0);

    // Drop from UP: one low sample.
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drop_status", linkStatus, 0);
    checkOutput("drop_state", linkState, 0);
    checkOutput("drop_count", failCount, 1);

    // Glitch during HOLD restarts qualification without a failure.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(glitchSig[i], 1'b0, 1'b0);
      checkOutput($sformatf("glitch_state_%0d", i), linkState, glitchStates[i]);
    end
    checkOutput("glitch_status", linkStatus, 1);
    checkOutput("glitch_count", failCount, 1);

    // Repeated drops saturate the 2-bit counter at 3.
    expCount = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      expCount = (expCount < 3) ? expCount + 1 : 3;
      checkOutput($sformatf("sat_count_%0d", i), failCount, expCount);
      bringUp($sformatf("sat_up_%0d", i));
    end

    // Clear at saturation with link steady.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clr_alone_count", failCount, 0);
    checkOutput("clr_alone_status", linkStatus, 1);

    // Disable while UP counts as a failure.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("dis_status", linkStatus, 0);
    checkOutput("dis_count", failCount, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("dis_held_state", linkState, 0);
    bringUp("dis_reup");

    // Clear together with a drop leaves exactly one failure.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr_drop_count", failCount, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr_idle_count", failCount, 0);

    // Reset in HOLD with timer=3 and a non-zero count.
    bringUp("rstmid_up");
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rstmid_pre_state", linkState, 1);
    checkOutput("rstmid_pre_count", failCount, 1);
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    rstN = 1'b1;
    checkOutput("rsthold_state", linkState, 0);
    checkOutput("rsthold_status", linkStatus, 0);
    checkOutput("rsthold_count", failCount, 0);
    checkOutput("rsthold_evt", linkUpEvt, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rsthold_timer_cleared", linkState, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rsthold_reup", linkState, 2);

    // Reset in UP is not a failure.
    applyStimulus(1'b0, 1'b0, 1'b0);
    bringUp("rstup_up");
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    rstN = 1'b1;
    checkOutput("rstup_status", linkStatus, 0);
    checkOutput("rstup_count", failCount, 0);
    checkOutput("rstup_state", linkState, 0);

    // Minimum stabilization: UP after exactly two high samples.
    sigMin = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("min_state_0", linkStateMin, 1);
    checkOutput("min_status_0", linkStatusMin, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("min_state_1", linkStateMin, 2);
    checkOutput("min_status_1", linkStatusMin, 1);
    checkOutput("min_evt_1", linkUpEvtMin, 1);

    // Illegal encoding recovers to DOWN even with signal present.
    force dutMin.state_q = link_state_e'(2'd3);
    #1;
    release dutMin.state_q;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("illegal_state", linkStateMin, 0);
    checkOutput("illegal_status", linkStatusMin, 0);
    checkOutput("illegal_count", failCountMin, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount_n);
    $finish;
  end

endmodule
